// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous clock-like input in clk_in cycles.
// Publishes on each detected rising edge, flags equal consecutive periods and missing edges.
module clk_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stable,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic             s1_q, s2_q, d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic             valid_q, stable_q, timeout_q, have_prev_q;
  logic             rise, fall;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  assign rise  = s2_q & ~d_q;
  assign fall  = ~s2_q & d_q;
  assign cnt_d = cnt_q + CNT_ONE;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      stable_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!en) begin
        // Disabled: drop any partial count; published values hold.
        state_q     <= IDLE;
        cnt_q       <= '0;
        hi_lat_q    <= '0;
        have_prev_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q       <= '0;
            hi_lat_q    <= '0;
            have_prev_q <= 1'b0;
            state_q     <= ARM;
          end
          ARM: begin
            cnt_q    <= '0;
            hi_lat_q <= '0;
            // First edge only starts timing; nothing is published here.
            if (rise) begin
              cnt_q   <= CNT_ONE;
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q    <= cnt_q;
              high_time_q <= hi_lat_q;
              valid_q     <= 1'b1;
              timeout_q   <= 1'b0;
              stable_q    <= (cnt_q == period_q) && have_prev_q;
              have_prev_q <= 1'b1;
              cnt_q       <= CNT_ONE;
              hi_lat_q    <= '0;
            end else if (cnt_q == CNT_MAX) begin
              // Checked before increment so cnt never wraps.
              timeout_q   <= 1'b1;
              stable_q    <= 1'b0;
              have_prev_q <= 1'b0;
              cnt_q       <= '0;
              hi_lat_q    <= '0;
              state_q     <= ARM;
            end else begin
              if (fall) hi_lat_q <= cnt_q;
              cnt_q <= cnt_d;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign stable    = stable_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures the divided clock produced by the clock divider, counted in clk_in cycles: full period and high time per cycle.
- Sits directly downstream of the divider's clk_out.
- Supplies on-chip self-check of the selected scale: measured values, valid strobe, stability flag and timeout flag.
- Treats sig_in as asynchronous, so it can also monitor an external pin.

Parameters:
- CNT_W, 16: width of the period/high-time counters and outputs; maximum measurable interval is 2^CNT_W-1 cycles.

Ports:
- clk_in  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  measurement enable; low forces IDLE
- sig_in  input  1  signal under measurement (divider clk_out); asynchronous
- period  output  CNT_W  clk_in cycles between last two detected rising edges of sig_in
- high_time  output  CNT_W  clk_in cycles sig_in was high within that period
- valid  output  1  one-cycle pulse when period/high_time update
- stable  output  1  high while the last two published periods are equal
- timeout  output  1  high when no rising edge was seen within 2^CNT_W-1 cycles; cleared by the next valid

Behaviour:
- Reset (async, rst=1): all outputs 0; counters 0; sync flops 0; state IDLE.
- Input path:
  - 2-flop synchronizer s1->s2, plus delay flop d.
  - rise = s2 & ~d; fall = ~s2 & d.
  - Pulses narrower than one clk_in period may be missed; this is acceptable.
- Latency: sig_in first sampled high at edge k -> rise true after edge k+1 -> period/high_time/valid registered at edge k+2; valid high for exactly one cycle.
- State IDLE:
  - cnt=0; valid=0.
  - period, high_time, stable and timeout hold their values.
  - en=1 -> ARM.
- State ARM:
  - cnt held at 0; waits for rise.
  - On rise: cnt<=1, goto MEASURE; no publish, because the first edge only starts timing.
- State MEASURE, each cycle:
  - No rise, no fall: cnt<=cnt+1.
  - fall: hi_lat<=cnt, and cnt<=cnt+1.
  - rise: period<=cnt; high_time<=hi_lat; valid<=1; timeout<=0; stable<=(cnt==period) && have_prev; have_prev<=1; cnt<=1; hi_lat<=0.
  - Timeout: when cnt==2^CNT_W-1 and no rise, timeout<=1, stable<=0, have_prev<=0, goto ARM; period/high_time hold.
- have_prev:
  - Internal flag, set after the first publish.
  - Cleared on reset, in IDLE and on timeout.
  - The first publish after arming therefore always reports stable=0.
- high_time = 0 when no falling edge occurred in the period (sig_in stuck high is reported via timeout instead).
- Simultaneous rise and fall in the same cycle is impossible after synchronization; no handling is required.
- en deassert in any state: next edge goes to IDLE, pending partial count discarded, valid forced 0. Re-assert restarts at ARM.
- rst mid-measurement: immediate clear of everything, including the synchronizer; the next measurement begins at ARM after release.
- Arithmetic: unsigned, CNT_W bits; cnt never wraps because the timeout check precedes increment overflow.
- Minimum measurable period = 2 (sig_in toggling every clk_in cycle): period=2, high_time=1.

Test Plan:
- Reset/idle: rst=1 mid-stream with period=37 published -> all outputs 0 on the same cycle (async); after release with en=0 and sig_in toggling -> valid never asserts.
- Steady divide:
  - Stimulus: en=1, sig_in = divided clock, 5 high / 5 low.
  - First rise: no valid.
  - Second rise: valid exactly 2 cycles after the sampling edge, with period=10, high_time=5, stable=0.
  - Third rise: stable=1; thereafter valid every 10 cycles.
- Period change: 10-cycle clock switched to 6 (3/3) -> first new publish period=6, high_time=3, stable=0; next publish stable=1.
- Minimum period: sig_in toggles every cycle -> period=2, high_time=1, valid every 2 cycles, stable=1 from the 2nd publish.
- Timeout (CNT_W=8): after one publish of period=10, hold sig_in low -> timeout=1 exactly 255 cycles after the last rise cycle, stable=0, period still 10. Resume the 10-cycle clock -> first rise re-arms without valid; second rise gives valid, period=10, timeout=0.
- Enable drop: en=0 mid-period of a 10-cycle clock for 4 cycles, then en=1 -> no valid for the partial period; the first valid comes after two post-enable rises, with period=10 and stable=0.
